// File: rtl/friet_pkg.sv
// Shared Friet-P constants, types and helpers for the round engine.
package friet_pkg;

    localparam int unsigned LIMB_W = 128;
    localparam int unsigned R1     = 1;
    localparam int unsigned R2     = 80;
    localparam int unsigned R3     = 36;
    localparam int unsigned R4     = 67;
    localparam int unsigned RC_N   = 24;
    localparam int unsigned RC_W   = 32;
    localparam int unsigned RIDX_W = 5;

    typedef logic [LIMB_W-1:0] limb_t;

    typedef struct packed {
        limb_t a;
        limb_t b;
        limb_t c;
    } friet_state_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } fsm_state_t;

    localparam logic [RC_W-1:0] FRIET_P_RC [0:RC_N-1] = '{
        32'h0000_1111, 32'h1110_0000, 32'h0000_1101, 32'h1010_0000,
        32'h0000_0101, 32'h1011_0000, 32'h0000_0110, 32'h1100_0000,
        32'h0000_1001, 32'h0010_0000, 32'h0000_0100, 32'h1000_0000,
        32'h0000_0001, 32'h0011_0000, 32'h0000_0010, 32'h0110_0000,
        32'h0000_1100, 32'h0100_0000, 32'h0000_1000, 32'h0001_0000,
        32'h0000_0011, 32'h0111_0000, 32'h0000_1110, 32'h1111_0000
    };

    function automatic limb_t rotl(input limb_t x, input int unsigned r);
        return (x << r) | (x >> (LIMB_W - r));
    endfunction

    // Indices past the table yield a zero constant.
    function automatic logic [RC_W-1:0] round_const(input logic [RIDX_W-1:0] idx);
        return (32'(idx) < RC_N) ? FRIET_P_RC[idx] : '0;
    endfunction

endpackage

// File: rtl/friet_p_round.sv
// One combinational Friet-P round: delta, tau, mu1, mu2, xi.
module friet_p_round
    import friet_pkg::*;
(
    input  logic [RIDX_W-1:0] rnd_idx,
    input  limb_t             a_in,
    input  limb_t             b_in,
    input  limb_t             c_in,
    output limb_t             a_out_c,
    output limb_t             b_out_c,
    output limb_t             c_out_c
);

    limb_t rc_w;
    limb_t a_dl, c_dl;
    limb_t a_tau, b_tau;
    limb_t b_m1, c_m1;
    limb_t a_m2, c_m2;
    limb_t xi_x, xi_y;

    // Linear layers; tau leaves c untouched since c = a ^ b is symmetric.
    always_comb begin
        rc_w  = LIMB_W'(round_const(rnd_idx));
        a_dl  = a_in ^ rc_w;
        c_dl  = c_in ^ rc_w;
        a_tau = b_in;
        b_tau = a_dl;
        b_m1  = b_tau ^ rotl(a_tau, R1);
        c_m1  = c_dl ^ rotl(a_tau, R1);
        a_m2  = a_tau ^ rotl(b_m1, R2);
        c_m2  = c_m1 ^ rotl(b_m1, R2);
        xi_x  = rotl(b_m1, R3);
        xi_y  = rotl(c_m2, R4);
    end

    friet_p_xaon #(.W(LIMB_W)) u_xaon_a (
        .x   (xi_x),
        .y   (xi_y),
        .z   (a_m2),
        .o_c (a_out_c)
    );

    friet_p_xaon #(.W(LIMB_W)) u_xaon_c (
        .x   (xi_x),
        .y   (xi_y),
        .z   (c_m2),
        .o_c (c_out_c)
    );

    assign b_out_c = b_m1;

endmodule

// File: rtl/friet_p_xaon.sv
// Bitwise xaon gate array: o = (x & y) ^ z.
module friet_p_xaon
    import friet_pkg::*;
#(
    parameter int unsigned W = LIMB_W
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic [W-1:0] z,
    output logic [W-1:0] o_c
);

    assign o_c = (x & y) ^ z;

endmodule

// File: rtl/friet_p_round_engine.sv
// Iterative Friet-P permutation engine with valid/ready load and unload ports.
// Optional code-invariant checker enabled by defining FRIET_P_FAULT_CHECK_EN.
module friet_p_round_engine
    import friet_pkg::*;
#(
    parameter int unsigned ROUNDS           = 24,
    parameter int unsigned ROUNDS_PER_CYCLE = 1
) (
    input  logic              clk,
    input  logic              arstn,
    input  logic [LIMB_W-1:0] din_a,
    input  logic [LIMB_W-1:0] din_b,
    input  logic [LIMB_W-1:0] din_c,
    input  logic              din_valid,
    output logic              din_ready,
    output logic [LIMB_W-1:0] dout_a,
    output logic [LIMB_W-1:0] dout_b,
    output logic [LIMB_W-1:0] dout_c,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              busy,
    output logic              fault
);

    localparam int unsigned CNT_W = $clog2(ROUNDS + 1);

    fsm_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    limb_t            a_q, a_d, b_q, b_d, c_q, c_d;
    logic             din_ready_q, din_ready_d;
    logic             dout_valid_q, dout_valid_d;
    logic             busy_q, busy_d;
`ifdef FRIET_P_FAULT_CHECK_EN
    logic             fault_q, fault_d;
`endif

    limb_t ch_a [0:ROUNDS_PER_CYCLE];
    limb_t ch_b [0:ROUNDS_PER_CYCLE];
    limb_t ch_c [0:ROUNDS_PER_CYCLE];

    assign ch_a[0] = a_q;
    assign ch_b[0] = b_q;
    assign ch_c[0] = c_q;

    // Unrolled round chain covering rounds cnt .. cnt+ROUNDS_PER_CYCLE-1.
    for (genvar j = 0; j < ROUNDS_PER_CYCLE; j++) begin : g_round
        friet_p_round u_round (
            .rnd_idx (RIDX_W'(cnt_q + CNT_W'(j))),
            .a_in    (ch_a[j]),
            .b_in    (ch_b[j]),
            .c_in    (ch_c[j]),
            .a_out_c (ch_a[j+1]),
            .b_out_c (ch_b[j+1]),
            .c_out_c (ch_c[j+1])
        );
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        a_d          = a_q;
        b_d          = b_q;
        c_d          = c_q;
        din_ready_d  = din_ready_q;
        dout_valid_d = dout_valid_q;
        busy_d       = busy_q;
`ifdef FRIET_P_FAULT_CHECK_EN
        fault_d      = fault_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (din_valid && din_ready_q) begin
                    a_d         = din_a;
                    b_d         = din_b;
                    c_d         = din_c;
                    cnt_d       = '0;
                    state_d     = ST_RUN;
                    din_ready_d = 1'b0;
                    busy_d      = 1'b1;
`ifdef FRIET_P_FAULT_CHECK_EN
                    if (din_c != (din_a ^ din_b)) fault_d = 1'b1;
`endif
                end
            end
            ST_RUN: begin
                a_d   = ch_a[ROUNDS_PER_CYCLE];
                b_d   = ch_b[ROUNDS_PER_CYCLE];
                c_d   = ch_c[ROUNDS_PER_CYCLE];
                cnt_d = cnt_q + CNT_W'(ROUNDS_PER_CYCLE);
`ifdef FRIET_P_FAULT_CHECK_EN
                if (c_d != (a_d ^ b_d)) fault_d = 1'b1;
`endif
                if (cnt_d == CNT_W'(ROUNDS)) begin
                    state_d      = ST_DONE;
                    busy_d       = 1'b0;
                    dout_valid_d = 1'b1;
                end
            end
            ST_DONE: begin
                if (dout_ready) begin
                    state_d      = ST_IDLE;
                    dout_valid_d = 1'b0;
                    din_ready_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            a_q          <= '0;
            b_q          <= '0;
            c_q          <= '0;
            din_ready_q  <= 1'b1;
            dout_valid_q <= 1'b0;
            busy_q       <= 1'b0;
`ifdef FRIET_P_FAULT_CHECK_EN
            fault_q      <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            a_q          <= a_d;
            b_q          <= b_d;
            c_q          <= c_d;
            din_ready_q  <= din_ready_d;
            dout_valid_q <= dout_valid_d;
            busy_q       <= busy_d;
`ifdef FRIET_P_FAULT_CHECK_EN
            fault_q      <= fault_d;
`endif
        end
    end

    assign din_ready  = din_ready_q;
    assign dout_valid = dout_valid_q;
    assign busy       = busy_q;

`ifdef FRIET_P_FAULT_CHECK_EN
    // A corrupted state is never released downstream.
    assign dout_a = fault_q ? '0 : a_q;
    assign dout_b = fault_q ? '0 : b_q;
    assign dout_c = fault_q ? '0 : c_q;
    assign fault  = fault_q;
`else
    assign dout_a = a_q;
    assign dout_b = b_q;
    assign dout_c = c_q;
    assign fault  = 1'b0;
`endif

endmodule
